// File: rtl/reservation_station_pkg.sv
// rtl/reservation_station_pkg.sv - shared widths, opcode encodings and tag constants
package reservation_station_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int ROB_POS_W = 5;
  localparam int OPENUM_W  = 6;
  localparam int NO_DEP    = 0;

  typedef enum logic [OPENUM_W-1:0] {
    OP_NONE = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SLT  = 6'd8,
    OP_BEQ  = 6'd9,
    OP_BNE  = 6'd10,
    OP_JAL  = 6'd11,
    OP_JALR = 6'd12
  } openum_e;

endpackage

// File: rtl/rs_find_first.sv
// rtl/rs_find_first.sv - lowest-index priority encoder returning {found, index}
module rs_find_first #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station with broadcast wakeup and in-order-by-slot dispatch
module reservation_station #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 5,
  parameter int OPENUM_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 issue_enable,
  input  logic                 rs_enable,
  input  logic [OPENUM_W-1:0]  issue_openum,
  input  logic [31:0]          issue_rs1_val,
  input  logic [31:0]          issue_rs2_val,
  input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
  input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_POS_W-1:0] issue_rob_pos,
  input  logic                 alu_result_ready,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_load_result_ready,
  input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
  input  logic [31:0]          lsb_load_result_val,
  output logic                 rs_full,
  output logic                 alu_enable,
  output logic [OPENUM_W-1:0]  alu_openum,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);
  import reservation_station_pkg::*;

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ROB_POS_W-1:0] NO_TAG = ROB_POS_W'(NO_DEP);

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   ready_vec;
  logic [OPENUM_W-1:0]  e_op   [RS_SIZE];
  logic [DATA_W-1:0]    e_val1 [RS_SIZE];
  logic [DATA_W-1:0]    e_val2 [RS_SIZE];
  logic [ROB_POS_W-1:0] e_tag1 [RS_SIZE];
  logic [ROB_POS_W-1:0] e_tag2 [RS_SIZE];
  logic [DATA_W-1:0]    e_imm  [RS_SIZE];
  logic [DATA_W-1:0]    e_pc   [RS_SIZE];
  logic [ROB_POS_W-1:0] e_rob  [RS_SIZE];
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 free_found, disp_found, do_issue, do_disp;
  logic [IDX_W-1:0]     free_idx, disp_idx;

  // Returns {tag, value} after snooping both result buses; ALU wins a tie.
  function automatic logic [ROB_POS_W+DATA_W-1:0] resolve(
    input logic [ROB_POS_W-1:0] tag,
    input logic [DATA_W-1:0]    val
  );
    if (tag != NO_TAG && alu_result_ready && alu_result_rob_pos == tag)
      return {NO_TAG, alu_result_val};
    else if (tag != NO_TAG && lsb_load_result_ready && lsb_load_result_rob_pos == tag)
      return {NO_TAG, lsb_load_result_val};
    else
      return {tag, val};
  endfunction

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++)
      ready_vec[i] = busy[i] && e_tag1[i] == NO_TAG && e_tag2[i] == NO_TAG;
  end

  rs_find_first #(.N(RS_SIZE)) u_free (.vec(~busy), .found(free_found), .idx(free_idx));
  rs_find_first #(.N(RS_SIZE)) u_disp (.vec(ready_vec), .found(disp_found), .idx(disp_idx));

  assign do_issue = issue_enable && rs_enable && free_found;
  assign do_disp  = disp_found;
  assign cnt_next = cnt + CNT_W'(do_issue) - CNT_W'(do_disp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy        <= '0;
      cnt         <= '0;
      rs_full     <= 1'b0;
      alu_enable  <= 1'b0;
      alu_openum  <= '0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (clr) begin
        busy       <= '0;
        cnt        <= '0;
        rs_full    <= 1'b0;
        alu_enable <= 1'b0;
      end else begin
        assert (free_found || !(issue_enable && rs_enable))
          else $error("reservation_station: issue while full, instruction dropped");
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            {e_tag1[i], e_val1[i]} <= resolve(e_tag1[i], e_val1[i]);
            {e_tag2[i], e_val2[i]} <= resolve(e_tag2[i], e_val2[i]);
          end
        end
        alu_enable <= do_disp;
        if (do_disp) begin
          busy[disp_idx] <= 1'b0;
          alu_openum     <= e_op[disp_idx];
          alu_val1       <= e_val1[disp_idx];
          alu_val2       <= e_val2[disp_idx];
          alu_imm        <= e_imm[disp_idx];
          alu_pc         <= e_pc[disp_idx];
          alu_rob_pos    <= e_rob[disp_idx];
        end
        // The free slot is never busy, so this cannot collide with wakeup or dispatch.
        if (do_issue) begin
          busy[free_idx]                     <= 1'b1;
          e_op[free_idx]                     <= issue_openum;
          {e_tag1[free_idx], e_val1[free_idx]} <= resolve(issue_rs1_rob_pos, issue_rs1_val);
          {e_tag2[free_idx], e_val2[free_idx]} <= resolve(issue_rs2_rob_pos, issue_rs2_val);
          e_imm[free_idx]                    <= issue_imm;
          e_pc[free_idx]                     <= issue_pc;
          e_rob[free_idx]                    <= issue_rob_pos;
        end
        cnt     <= cnt_next;
        rs_full <= cnt_next >= CNT_W'(RS_SIZE - 1);
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, issue_enable, rs_enable;
  logic [5:0]  issue_openum;
  logic [31:0] issue_rs1_val, issue_rs2_val, issue_imm, issue_pc;
  logic [4:0]  issue_rs1_rob_pos, issue_rs2_rob_pos, issue_rob_pos;
  logic        alu_result_ready, lsb_load_result_ready;
  logic [4:0]  alu_result_rob_pos, lsb_load_result_rob_pos;
  logic [31:0] alu_result_val, lsb_load_result_val;
  logic        rs_full, alu_enable;
  logic [5:0]  alu_openum;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [4:0]  alu_rob_pos;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .issue_enable(issue_enable), .rs_enable(rs_enable),
    .issue_openum(issue_openum),
    .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
    .issue_rs1_rob_pos(issue_rs1_rob_pos), .issue_rs2_rob_pos(issue_rs2_rob_pos),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_pos(issue_rob_pos),
    .alu_result_ready(alu_result_ready), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_load_result_ready(lsb_load_result_ready),
    .lsb_load_result_rob_pos(lsb_load_result_rob_pos),
    .lsb_load_result_val(lsb_load_result_val),
    .rs_full(rs_full), .alu_enable(alu_enable), .alu_openum(alu_openum),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_enable = 0; rs_enable = 1; issue_openum = 0;
    issue_rs1_val = 0; issue_rs2_val = 0; issue_rs1_rob_pos = 0; issue_rs2_rob_pos = 0;
    issue_imm = 0; issue_pc = 0; issue_rob_pos = 0;
    alu_result_ready = 0; alu_result_rob_pos = 0; alu_result_val = 0;
    lsb_load_result_ready = 0; lsb_load_result_rob_pos = 0; lsb_load_result_val = 0;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] t1,
                     input logic [31:0] v2, input logic [4:0] t2, input logic [4:0] rob);
    issue_enable = 1; issue_openum = op;
    issue_rs1_val = v1; issue_rs1_rob_pos = t1;
    issue_rs2_val = v2; issue_rs2_rob_pos = t2;
    issue_imm = 32'h1000 + 32'(rob); issue_pc = 32'h4000 + 32'(rob) * 4; issue_rob_pos = rob;
  endtask

  initial begin
    rst = 0; rdy = 1; clr = 0;
    idle();
    tick(); tick();
    chk("rst_en", 32'(alu_enable), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_op", 32'(alu_openum), 0);
    chk("rst_v1", alu_val1, 0);
    chk("rst_v2", alu_val2, 0);
    chk("rst_imm", alu_imm, 0);
    chk("rst_pc", alu_pc, 0);
    chk("rst_rob", 32'(alu_rob_pos), 0);
    chk("rst_cnt", 32'(dut.cnt), 0);
    rst = 1;

    // issue_enable without rs_enable is ignored
    put(6'd1, 32'd5, 0, 32'd7, 0, 5'd3); rs_enable = 0;
    tick(); idle();
    chk("gate_cnt", 32'(dut.cnt), 0);

    // ready issue dispatches one cycle later
    put(6'd1, 32'd5, 0, 32'd7, 0, 5'd3);
    tick(); idle();
    chk("rdy_en0", 32'(alu_enable), 0);
    chk("rdy_cnt1", 32'(dut.cnt), 1);
    tick();
    chk("rdy_en", 32'(alu_enable), 1);
    chk("rdy_v1", alu_val1, 5);
    chk("rdy_v2", alu_val2, 7);
    chk("rdy_rob", 32'(alu_rob_pos), 3);
    chk("rdy_op", 32'(alu_openum), 1);
    chk("rdy_imm", alu_imm, 32'h1003);
    chk("rdy_pc", alu_pc, 32'h400c);
    tick();
    chk("rdy_pulse", 32'(alu_enable), 0);
    chk("rdy_cnt0", 32'(dut.cnt), 0);

    // ALU wakeup two cycles after issue
    put(6'd2, 32'h99, 5'd4, 32'd2, 0, 5'd5);
    tick(); idle();
    tick();
    chk("wk_wait", 32'(alu_enable), 0);
    alu_result_ready = 1; alu_result_rob_pos = 4; alu_result_val = 32'h10;
    tick(); idle();
    chk("wk_nosame", 32'(alu_enable), 0);
    tick();
    chk("wk_en", 32'(alu_enable), 1);
    chk("wk_v1", alu_val1, 32'h10);
    chk("wk_v2", alu_val2, 2);
    chk("wk_rob", 32'(alu_rob_pos), 5);
    tick();

    // issue-time bypass: tag1 from LSB, tag2 from ALU in the same cycle
    put(6'd3, 32'h0, 5'd4, 32'h0, 5'd6, 5'd8);
    lsb_load_result_ready = 1; lsb_load_result_rob_pos = 4; lsb_load_result_val = 32'h20;
    alu_result_ready = 1; alu_result_rob_pos = 6; alu_result_val = 32'h66;
    tick(); idle();
    chk("byp_en0", 32'(alu_enable), 0);
    tick();
    chk("byp_en", 32'(alu_enable), 1);
    chk("byp_v1", alu_val1, 32'h20);
    chk("byp_v2", alu_val2, 32'h66);
    chk("byp_rob", 32'(alu_rob_pos), 8);
    tick();

    // fill 15 dependent entries
    for (int i = 0; i < 15; i++) begin
      put(6'd4, 32'h0, 5'd9, 32'(i), 0, 5'(16 + i));
      tick(); idle();
      chk($sformatf("fill_full%0d", i), 32'(rs_full), (i == 14) ? 1 : 0);
    end
    chk("fill_cnt", 32'(dut.cnt), 15);
    chk("fill_en", 32'(alu_enable), 0);

    alu_result_ready = 1; alu_result_rob_pos = 9; alu_result_val = 32'h900;
    tick(); idle();
    chk("wk9_en", 32'(alu_enable), 0);

    // simultaneous issue and dispatch at cnt=15
    put(6'd5, 32'h0, 5'd12, 32'h0, 0, 5'd31);
    tick(); idle();
    chk("sim_en", 32'(alu_enable), 1);
    chk("sim_rob", 32'(alu_rob_pos), 16);
    chk("sim_v1", alu_val1, 32'h900);
    chk("sim_cnt", 32'(dut.cnt), 15);
    chk("sim_full", 32'(rs_full), 1);
    chk("sim_busy15", 32'(dut.busy[15]), 1);
    chk("sim_busy0", 32'(dut.busy[0]), 0);
    for (int j = 1; j < 15; j++) begin
      tick();
      chk($sformatf("drain_en%0d", j), 32'(alu_enable), 1);
      chk($sformatf("drain_rob%0d", j), 32'(alu_rob_pos), 32'(16 + j));
      chk($sformatf("drain_v2_%0d", j), alu_val2, 32'(j));
      chk($sformatf("drain_full%0d", j), 32'(rs_full), (15 - j >= 15) ? 1 : 0);
    end
    tick();
    chk("drain_done", 32'(alu_enable), 0);
    chk("drain_cnt", 32'(dut.cnt), 1);

    // rdy low freezes state
    put(6'd1, 32'd1, 0, 32'd1, 0, 5'd7);
    tick(); idle();
    rdy = 0;
    tick(); tick();
    chk("frz_en", 32'(alu_enable), 0);
    chk("frz_cnt", 32'(dut.cnt), 2);
    rdy = 1;
    tick();
    chk("frz_go", 32'(alu_enable), 1);
    chk("frz_rob", 32'(alu_rob_pos), 7);
    tick();

    // flush with 6 pending entries
    for (int k = 0; k < 5; k++) begin
      put(6'd6, 32'h0, 5'd13, 32'h0, 0, 5'(k + 1));
      tick(); idle();
    end
    chk("fl_cnt6", 32'(dut.cnt), 6);
    clr = 1;
    tick();
    clr = 0;
    chk("fl_en", 32'(alu_enable), 0);
    chk("fl_cnt", 32'(dut.cnt), 0);
    chk("fl_full", 32'(rs_full), 0);
    alu_result_ready = 1; alu_result_rob_pos = 12; alu_result_val = 32'h12;
    lsb_load_result_ready = 1; lsb_load_result_rob_pos = 13; lsb_load_result_val = 32'h13;
    tick(); idle();
    chk("fl_quiet1", 32'(alu_enable), 0);
    tick();
    chk("fl_quiet2", 32'(alu_enable), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
